// File: rtl/rc4_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rc4_pkg: shared constants and state encoding for the RC4 PRGA decrypter    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package rc4_pkg;

   localparam int MSG_LEN_DEFAULT = 32;

   localparam logic [7:0] ASCII_LO    = 8'h61;
   localparam logic [7:0] ASCII_HI    = 8'h7A;
   localparam logic [7:0] ASCII_SPACE = 8'h20;

   typedef logic [3:0] state_t;

   localparam state_t ST_IDLE  = 4'd0;
   localparam state_t ST_INC_I = 4'd1;
   localparam state_t ST_RD_I  = 4'd2;
   localparam state_t ST_WT_I  = 4'd3;
   localparam state_t ST_GET_I = 4'd4;
   localparam state_t ST_RD_J  = 4'd5;
   localparam state_t ST_WT_J  = 4'd6;
   localparam state_t ST_GET_J = 4'd7;
   localparam state_t ST_WR_I  = 4'd8;
   localparam state_t ST_WR_J  = 4'd9;
   localparam state_t ST_RD_F  = 4'd10;
   localparam state_t ST_WT_F  = 4'd11;
   localparam state_t ST_GET_F = 4'd12;
   localparam state_t ST_WR_D  = 4'd13;
   localparam state_t ST_NEXT  = 4'd14;
   localparam state_t ST_DONE  = 4'd15;

endpackage
`default_nettype wire

// File: rtl/rc4_char_check.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rc4_char_check: flags a byte as plausible plaintext (lowercase or space)   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rc4_char_check
   import rc4_pkg::*;
(
   input  logic [7:0] char_in,
   output logic       char_ok
);

   assign char_ok = ((char_in >= ASCII_LO) && (char_in <= ASCII_HI)) ||
                    (char_in == ASCII_SPACE);

endmodule
`default_nettype wire

// File: rtl/rc4_prga_decrypt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rc4_prga_decrypt: RC4 PRGA over S RAM, XORs keystream with message ROM     |
// | Optional plaintext check enabled by RC4_PRGA_ASCII_CHECK_EN. Rev 1.0       |
// +----------------------------------------------------------------------------+
module rc4_prga_decrypt
   import rc4_pkg::*;
#(
   parameter int MSG_LEN = MSG_LEN_DEFAULT
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       Start,
   input  logic       Finish_ack,
   input  logic [7:0] s_q,
   output logic [7:0] s_addr,
   output logic [7:0] s_data,
   output logic       s_wren,
   input  logic [7:0] rom_q,
   output logic [4:0] rom_addr,
   output logic [4:0] d_addr,
   output logic [7:0] d_data,
   output logic       d_wren,
   output logic       Done,
   output logic       Key_Valid
);

   localparam logic [4:0] K_LAST = 5'(MSG_LEN - 1);

   state_t     state_q, state_d;
   logic [7:0] i_q, i_d, j_q, j_d;
   logic [7:0] si_q, si_d, sj_q, sj_d;
   logic [7:0] f_q, f_d, e_q, e_d;
   logic [4:0] k_q, k_d;
   logic       kv_q, kv_d;
   logic [7:0] plain;
   logic       char_ok;

   assign plain = f_q ^ e_q;

`ifdef RC4_PRGA_ASCII_CHECK_EN
   rc4_char_check u_char_check (
      .char_in (plain),
      .char_ok (char_ok)
   );
`else
   assign char_ok = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         i_q     <= 8'd0;
         j_q     <= 8'd0;
         si_q    <= 8'd0;
         sj_q    <= 8'd0;
         f_q     <= 8'd0;
         e_q     <= 8'd0;
         k_q     <= 5'd0;
         kv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         si_q    <= si_d;
         sj_q    <= sj_d;
         f_q     <= f_d;
         e_q     <= e_d;
         k_q     <= k_d;
         kv_q    <= kv_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      i_d      = i_q;
      j_d      = j_q;
      si_d     = si_q;
      sj_d     = sj_q;
      f_d      = f_q;
      e_d      = e_q;
      k_d      = k_q;
      kv_d     = kv_q;
      s_addr   = 8'd0;
      s_data   = 8'd0;
      s_wren   = 1'b0;
      rom_addr = 5'd0;
      d_addr   = 5'd0;
      d_data   = 8'd0;
      d_wren   = 1'b0;
      Done     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            i_d = 8'd0;
            j_d = 8'd0;
            k_d = 5'd0;
            if (Start) begin
               kv_d    = 1'b1;
               state_d = ST_INC_I;
            end
         end
         ST_INC_I: begin
            i_d     = i_q + 8'd1;
            state_d = ST_RD_I;
         end
         ST_RD_I: begin
            s_addr  = i_q;
            state_d = ST_WT_I;
         end
         ST_WT_I:  state_d = ST_GET_I;
         ST_GET_I: begin
            si_d    = s_q;
            j_d     = j_q + s_q;
            state_d = ST_RD_J;
         end
         ST_RD_J: begin
            s_addr  = j_q;
            state_d = ST_WT_J;
         end
         ST_WT_J:  state_d = ST_GET_J;
         ST_GET_J: begin
            sj_d    = s_q;
            state_d = ST_WR_I;
         end
         // When i==j both writes land on one address; the second (si) wins.
         ST_WR_I: begin
            s_addr  = i_q;
            s_data  = sj_q;
            s_wren  = 1'b1;
            state_d = ST_WR_J;
         end
         ST_WR_J: begin
            s_addr  = j_q;
            s_data  = si_q;
            s_wren  = 1'b1;
            state_d = ST_RD_F;
         end
         ST_RD_F: begin
            s_addr   = si_q + sj_q;
            rom_addr = k_q;
            state_d  = ST_WT_F;
         end
         ST_WT_F:  state_d = ST_GET_F;
         ST_GET_F: begin
            f_d     = s_q;
            e_d     = rom_q;
            state_d = ST_WR_D;
         end
         ST_WR_D: begin
            d_addr = k_q;
            d_data = plain;
            if (char_ok) begin
               d_wren  = 1'b1;
               state_d = ST_NEXT;
            end else begin
               kv_d    = 1'b0;
               state_d = ST_DONE;
            end
         end
         ST_NEXT: begin
            if (k_q == K_LAST) begin
               state_d = ST_DONE;
            end else begin
               k_d     = k_q + 5'd1;
               state_d = ST_INC_I;
            end
         end
         ST_DONE: begin
            Done = 1'b1;
            if (Finish_ack) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign Key_Valid = (state_q == ST_DONE) && kv_q;

endmodule
`default_nettype wire

// File: tb/tb_rc4_prga_decrypt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rc4_prga_decrypt: scoreboard bench with RAM/ROM models and an RC4 model |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_rc4_prga_decrypt;

   localparam int MSG_LEN = 9;

   logic       clk = 1'b0;
   logic       rst;
   logic       Start;
   logic       Finish_ack;
   logic [7:0] s_q;
   logic [7:0] s_addr;
   logic [7:0] s_data;
   logic       s_wren;
   logic [7:0] rom_q;
   logic [4:0] rom_addr;
   logic [4:0] d_addr;
   logic [7:0] d_data;
   logic       d_wren;
   logic       Done;
   logic       Key_Valid;

   rc4_prga_decrypt #(.MSG_LEN(MSG_LEN)) dut (
      .clk        (clk),
      .rst        (rst),
      .Start      (Start),
      .Finish_ack (Finish_ack),
      .s_q        (s_q),
      .s_addr     (s_addr),
      .s_data     (s_data),
      .s_wren     (s_wren),
      .rom_q      (rom_q),
      .rom_addr   (rom_addr),
      .d_addr     (d_addr),
      .d_data     (d_data),
      .d_wren     (d_wren),
      .Done       (Done),
      .Key_Valid  (Key_Valid)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Memories: address registered, data out one further cycle (RD -> WT -> GET).
   logic [7:0] s_mem  [256];
   logic [7:0] s_init [256];
   logic [7:0] rom    [32];
   logic [7:0] d_mem  [32];
   logic [7:0] s_addr_r;
   logic [4:0] rom_addr_r;
   logic       load_s = 1'b0;

   always @(posedge clk) begin
      s_addr_r   <= s_addr;
      s_q        <= s_mem[s_addr_r];
      rom_addr_r <= rom_addr;
      rom_q      <= rom[rom_addr_r];
      if (load_s) begin
         for (int x = 0; x < 256; x++) s_mem[x] <= s_init[x];
      end else if (s_wren) begin
         s_mem[s_addr] <= s_data;
      end
      if (d_wren) d_mem[d_addr] <= d_data;
   end

   typedef struct packed {
      logic [4:0] a;
      logic [7:0] d;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;

   always @(negedge clk) begin
      if (rst && d_wren) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL d_write: got addr=%0d data=%02h, required no write", d_addr, d_data);
         end else begin
            mon_e = exp_q.pop_front();
            if (d_addr !== mon_e.a || d_data !== mon_e.d) begin
               errors++;
               $display("FAIL d_write: got addr=%0d data=%02h, required addr=%0d data=%02h",
                        d_addr, d_data, mon_e.a, mon_e.d);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Reference RC4 model
   logic [7:0] m_s  [256];
   logic [7:0] m_ks [32];

   task automatic model_ksa(input logic [23:0] key);
      logic [7:0] j, t;
      logic [7:0] kb [3];
      kb[0] = key[23:16];
      kb[1] = key[15:8];
      kb[2] = key[7:0];
      for (int x = 0; x < 256; x++) m_s[x] = 8'(x);
      j = 8'd0;
      for (int x = 0; x < 256; x++) begin
         j = j + m_s[x] + kb[x % 3];
         t = m_s[x];
         m_s[x] = m_s[j];
         m_s[j] = t;
      end
   endtask

   task automatic model_prga(input int n);
      logic [7:0] i, j, t, idx;
      i = 8'd0;
      j = 8'd0;
      for (int k = 0; k < n; k++) begin
         i = i + 8'd1;
         j = j + m_s[i];
         t = m_s[i];
         m_s[i] = m_s[j];
         m_s[j] = t;
         idx = m_s[i] + m_s[j];
         m_ks[k] = m_s[idx];
      end
   endtask

   task automatic pulse_load;
      @(negedge clk);
      load_s = 1'b1;
      @(negedge clk);
      load_s = 1'b0;
   endtask

   // Key "Key", message "attack at" encrypted under the model keystream.
   task automatic prep_lowercase;
      logic [71:0] msg;
      msg = "attack at";
      model_ksa(24'h4B6579);
      for (int x = 0; x < 256; x++) s_init[x] = m_s[x];
      model_prga(MSG_LEN);
      for (int k = 0; k < MSG_LEN; k++) rom[k] = m_ks[k] ^ msg[71-8*k -: 8];
      pulse_load();
   endtask

   task automatic push_lowercase;
      logic [71:0] msg;
      msg = "attack at";
      for (int k = 0; k < MSG_LEN; k++) exp_q.push_back('{a: 5'(k), d: msg[71-8*k -: 8]});
   endtask

   task automatic run(input int mid_start_at, input int early_ack_at,
                      output int lat, output logic [7:0] sa5, output logic [4:0] ra10);
      @(negedge clk);
      Start = 1'b1;
      lat   = 0;
      sa5   = 8'hxx;
      ra10  = 5'hxx;
      while (lat < 2000) begin
         @(posedge clk);
         lat++;
         #1;
         Start      = (lat == mid_start_at);
         Finish_ack = (lat == early_ack_at);
         if (lat == 5)  sa5  = s_addr;
         if (lat == 10) ra10 = rom_addr;
         if (Done) break;
      end
      Start      = 1'b0;
      Finish_ack = 1'b0;
   endtask

   task automatic ack(input logic with_start);
      @(negedge clk);
      Finish_ack = 1'b1;
      Start      = with_start;
      @(posedge clk);
      #1;
      Finish_ack = 1'b0;
      Start      = 1'b0;
      chk("done_clear", Done, 0);
   endtask

   task automatic check_idle(input string name);
      int act = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (s_addr != 0 || s_wren || d_wren || Done || rom_addr != 0) act++;
      end
      chk(name, act, 0);
   endtask

   task automatic check_final_s(input string name);
      int mism = 0;
      for (int x = 0; x < 256; x++) if (s_mem[x] !== m_s[x]) mism++;
      chk(name, mism, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      int          found;
      logic        prev;
      logic [7:0]  sa5;
      logic [4:0]  ra10;
      logic [71:0] pt;
      logic [71:0] ct;

      rst        = 1'b0;
      Start      = 1'b0;
      Finish_ack = 1'b0;
      for (int x = 0; x < 32; x++) begin
         rom[x]   = 8'h00;
         d_mem[x] = 8'h00;
      end
      for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {s_addr, s_data, s_wren, rom_addr, d_addr, d_data, d_wren, Done, Key_Valid}, 0);
      @(negedge clk);
      rst = 1'b1;

      // Known vector: key "Key", ciphertext of "Plaintext"
      pt = "Plaintext";
      ct = 72'hBBF316E8D940AF0AD3;
      model_ksa(24'h4B6579);
      for (int x = 0; x < 256; x++) s_init[x] = m_s[x];
      for (int k = 0; k < MSG_LEN; k++) rom[k] = ct[71-8*k -: 8];
      pulse_load();
`ifdef RC4_PRGA_ASCII_CHECK_EN
      run(0, 0, lat, sa5, ra10);
      chk("vec_abort_latency", lat, 14);
      chk("vec_abort_done", Done, 1);
      chk("vec_abort_key_valid", Key_Valid, 0);
      ack(1'b0);
`else
      for (int k = 0; k < MSG_LEN; k++) exp_q.push_back('{a: 5'(k), d: pt[71-8*k -: 8]});
      run(0, 0, lat, sa5, ra10);
      chk("vec_latency", lat, 127);
      chk("vec_key_valid", Key_Valid, 1);
      model_prga(MSG_LEN);
      check_final_s("vec_final_s");
      ack(1'b0);

      // Identity S: first step has i==j==1, keystream byte 0 is S[2]=2
      for (int x = 0; x < 256; x++) begin
         s_init[x] = 8'(x);
         m_s[x]    = 8'(x);
      end
      for (int k = 0; k < MSG_LEN; k++) rom[k] = 8'h41 + 8'(k);
      pulse_load();
      model_prga(MSG_LEN);
      for (int k = 0; k < MSG_LEN; k++) exp_q.push_back('{a: 5'(k), d: rom[k] ^ m_ks[k]});
      // Start mid-run and an early Finish_ack must both be ignored
      run(50, 60, lat, sa5, ra10);
      chk("swap_latency", lat, 127);
      chk("swap_j_eq_i", sa5, 8'h01);
      chk("swap_d0", d_mem[0], 8'h43);
      repeat (3) @(posedge clk);
      #1;
      chk("done_held", Done, 1);
      check_final_s("swap_final_s");
      ack(1'b1);
      check_idle("no_restart_after_ack_with_start");
`endif

      // Lowercase message: valid in both builds
      prep_lowercase();
      push_lowercase();
      run(0, 0, lat, sa5, ra10);
      chk("lc_latency", lat, 127);
      chk("lc_key_valid", Key_Valid, 1);
      check_final_s("lc_final_s");
      ack(1'b0);

      // Reset asserted during WR_J of the first byte
      prep_lowercase();
      @(negedge clk);
      Start = 1'b1;
      @(posedge clk);
      #1;
      Start = 1'b0;
      found = 0;
      prev  = 1'b0;
      for (int n = 0; n < 40 && found == 0; n++) begin
         @(negedge clk);
         if (s_wren && prev) found = 1;
         prev = s_wren;
      end
      chk("wr_j_reached", found, 1);
      rst = 1'b0;
      #1;
      chk("async_reset_outputs", {s_addr, s_data, s_wren, rom_addr, d_addr, d_data, d_wren, Done, Key_Valid}, 0);
      @(posedge clk);
      #1;
      chk("reset_held_outputs", {s_addr, s_wren, rom_addr, d_wren, Done}, 0);
      @(negedge clk);
      rst = 1'b1;
      pulse_load();
      push_lowercase();
      run(0, 0, lat, sa5, ra10);
      chk("restart_rom_addr", ra10, 0);
      chk("restart_latency", lat, 127);
      chk("restart_key_valid", Key_Valid, 1);
      check_final_s("restart_final_s");
      ack(1'b0);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
